// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the load path.
// Contents:
//   LOAD_* : funct3 encodings for RV32I loads.
//   load_entry_t : one outstanding load, holding its destination, funct3 and address LSBs.
package cpu_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] lsbs;
    } load_entry_t;

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner. It selects the addressed byte or halfword
// from a 32-bit bus word, then sign- or zero-extends it.
// Ports:
//   word_i   : raw 32-bit word returned by memory.
//   funct3_i : load funct3.
//   lsbs_i   : load_address[1:0].
//   value_o  : aligned and extended register value.
// Encodings without a defined meaning (011/110/111) pass the word through unchanged.
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lsbs_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // Byte shift is lsbs*8. The halfword shift uses only lsbs[1], so a
        // misaligned halfword still reads the aligned half.
        byte_v = 8'(word_i >> {lsbs_i, 3'b000});
        half_v = 16'(word_i >> {lsbs_i[1], 4'b0000});
        case (funct3_i)
            LOAD_LB:  value_o = {{24{byte_v[7]}}, byte_v};
            LOAD_LBU: value_o = {24'h0, byte_v};
            LOAD_LH:  value_o = {{16{half_v[15]}}, half_v};
            LOAD_LHU: value_o = {16'h0, half_v};
            default:  value_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_load_writeback.sv
// Load completion unit. It tracks the loads issued on the system bus in an
// in-order queue. On each returned read word it pops the oldest entry, aligns
// the data and drives a registered register-file write. It also provides a
// load-use scoreboard for the issue stage.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset.
//   issue_*                     : load issue from execute (ready/enable/rd/funct3/addr lsbs).
//   system_bus_read_data[_valid]: returned read word, no backpressure.
//   rd, rd_value_write_*        : registered writeback, one-cycle strobe.
//   query_rs1/2, load_hazard    : scoreboard lookup.
//   loads_pending               : queue non-empty or writeback in flight.
//   load_error                  : sticky error flag.
// Configuration: when MEM_LOAD_ERROR_CHECK_EN is defined, load_error flags
// data returned with an empty queue and misaligned LH/LHU/LW issues.
// Otherwise load_error is tied to 0.
module mem_load_writeback
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        issue_ready,
    input  logic        issue_enable,
    input  logic [4:0]  issue_rd,
    input  logic [2:0]  issue_funct3,
    input  logic [1:0]  issue_addr_lsbs,
    input  logic [31:0] system_bus_read_data,
    input  logic        system_bus_read_data_valid,
    output logic [4:0]  rd,
    output logic        rd_value_write_enable,
    output logic [31:0] rd_value_write_data,
    input  logic [4:0]  query_rs1,
    input  logic [4:0]  query_rs2,
    output logic        load_hazard,
    output logic        loads_pending,
    output logic        load_error
);

    localparam int AW = $clog2(DEPTH);

    load_entry_t       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [4:0]        rd_q;
    logic              we_q;
    logic [31:0]       data_q;

    logic              push, pop, q_empty;
    load_entry_t       head;
    logic [31:0]       aligned;

    assign q_empty     = (count_q == '0);
    assign issue_ready = (count_q != (AW+1)'(DEPTH));
    // Ready comes only from the registered count, so a same-cycle pop cannot
    // make room for an issue into a full queue.
    assign push        = issue_enable & issue_ready;
    assign pop         = system_bus_read_data_valid & ~q_empty;
    assign head        = mem_q[rd_ptr_q];

    load_align u_align (
        .word_i   (system_bus_read_data),
        .funct3_i (head.funct3),
        .lsbs_i   (head.lsbs),
        .value_o  (aligned)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_q     <= '0;
            we_q     <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // The strobe is cleared unless this cycle pops, so each pop yields
            // exactly one write. A pop for x0 consumes its entry without writing.
            we_q     <= pop && (head.rd != 5'd0);
            if (pop) begin
                rd_q   <= head.rd;
                data_q <= aligned;
            end
        end
    end

    // Queue storage has no reset. Entries outside [rd_ptr, rd_ptr+count) are
    // never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{rd: issue_rd, funct3: issue_funct3, lsbs: issue_addr_lsbs};
    end

    // Scoreboard: an entry is live if its distance from rd_ptr is below count.
    // The writeback register still counts for one more cycle.
    always_comb begin
        logic [AW-1:0] off;
        logic          hz;
        off = '0;
        hz  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (mem_q[i].rd != 5'd0) &&
                ((mem_q[i].rd == query_rs1) || (mem_q[i].rd == query_rs2)))
                hz = 1'b1;
        end
        if (we_q && ((rd_q == query_rs1) || (rd_q == query_rs2)))
            hz = 1'b1;
        load_hazard = hz;
    end

    assign rd                    = rd_q;
    assign rd_value_write_enable = we_q;
    assign rd_value_write_data   = data_q;
    assign loads_pending         = ~q_empty | we_q;

`ifdef MEM_LOAD_ERROR_CHECK_EN
    logic err_q;
    logic err_evt;

    always_comb begin
        err_evt = system_bus_read_data_valid & q_empty;
        if (push) begin
            if (((issue_funct3 == LOAD_LH) || (issue_funct3 == LOAD_LHU)) && issue_addr_lsbs[0])
                err_evt = 1'b1;
            if ((issue_funct3 == LOAD_LW) && (issue_addr_lsbs != 2'b00))
                err_evt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)        err_q <= 1'b0;
        else if (err_evt) err_q <= 1'b1;
    end

    assign load_error = err_q;
`else
    assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_writeback.sv
module tb_mem_load_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_ready;
    logic        issue_enable;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_funct3;
    logic [1:0]  issue_addr_lsbs;
    logic [31:0] system_bus_read_data;
    logic        system_bus_read_data_valid;
    logic [4:0]  rd;
    logic        rd_value_write_enable;
    logic [31:0] rd_value_write_data;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        load_hazard;
    logic        loads_pending;
    logic        load_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_load_writeback #(.DEPTH(4)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .issue_ready                (issue_ready),
        .issue_enable               (issue_enable),
        .issue_rd                   (issue_rd),
        .issue_funct3               (issue_funct3),
        .issue_addr_lsbs            (issue_addr_lsbs),
        .system_bus_read_data       (system_bus_read_data),
        .system_bus_read_data_valid (system_bus_read_data_valid),
        .rd                         (rd),
        .rd_value_write_enable      (rd_value_write_enable),
        .rd_value_write_data        (rd_value_write_data),
        .query_rs1                  (query_rs1),
        .query_rs2                  (query_rs2),
        .load_hazard                (load_hazard),
        .loads_pending              (loads_pending),
        .load_error                 (load_error)
    );

`ifdef MEM_LOAD_ERROR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        issue_enable = 1'b0;
        system_bus_read_data_valid = 1'b0;
        do_reset();
        checks++;
        if (rd !== 5'd0 || rd_value_write_enable !== 1'b0 || rd_value_write_data !== 32'h0 ||
            load_error !== 1'b0 || issue_ready !== 1'b1 || loads_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rd=%0d we=%b data=%h err=%b ready=%b pend=%b, want 0 0 0 0 1 0",
                     rd, rd_value_write_enable, rd_value_write_data, load_error, issue_ready, loads_pending);
        end
    endtask

    // Issue one load, return one word, and check the registered writeback.
    task automatic single_load(input string name, input logic [4:0] r, input logic [2:0] f3,
                               input logic [1:0] lsbs, input logic [31:0] word, input logic [31:0] exp);
        issue_enable = 1'b1; issue_rd = r; issue_funct3 = f3; issue_addr_lsbs = lsbs;
        step();
        issue_enable = 1'b0;
        system_bus_read_data_valid = 1'b1; system_bus_read_data = word;
        step();
        system_bus_read_data_valid = 1'b0;
        checks++;
        if (rd !== r || rd_value_write_enable !== 1'b1 || rd_value_write_data !== exp) begin
            failures++;
            $display("FAIL %s: rd=%0d we=%b data=%h, want rd=%0d we=1 data=%h",
                     name, rd, rd_value_write_enable, rd_value_write_data, r, exp);
        end
        step();
        checks++;
        if (rd_value_write_enable !== 1'b0) begin
            failures++;
            $display("FAIL %s_strobe_len: we=%b, want 0", name, rd_value_write_enable);
        end
    endtask

    task automatic test_align();
        single_load("lb_l3",  5'd5, 3'b000, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80);
        single_load("lbu_l3", 5'd5, 3'b100, 2'd3, 32'h80FF_1234, 32'h0000_0080);
        single_load("lb_l1",  5'd6, 3'b000, 2'd1, 32'h0000_7F00, 32'h0000_007F);
        single_load("lh_l2",  5'd8, 3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
        single_load("lhu_l0", 5'd9, 3'b101, 2'd0, 32'h1234_ABCD, 32'h0000_ABCD);
        single_load("lw",     5'd10, 3'b010, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        single_load("f3_111", 5'd11, 3'b111, 2'd3, 32'h1357_9BDF, 32'h1357_9BDF);
    endtask

    // Fill the queue and drain it back-to-back. The first fill also tries an
    // issue while full in the same cycle as a return, and that issue must drop.
    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                issue_enable = 1'b1; issue_rd = 5'(1 + k + 4*f);
                issue_funct3 = 3'b010; issue_addr_lsbs = 2'd0;
                step();
            end
            issue_enable = 1'b0;
            checks++;
            if (issue_ready !== 1'b0) begin
                failures++;
                $display("FAIL full_ready fill%0d: issue_ready=%b, want 0", f, issue_ready);
            end
            for (int k = 0; k < 4; k++) begin
                system_bus_read_data_valid = 1'b1;
                system_bus_read_data = 32'hA000_0000 + 32'(f * 16 + k);
                if (f == 0 && k == 0) begin
                    issue_enable = 1'b1; issue_rd = 5'd31; issue_funct3 = 3'b010;
                end
                step();
                issue_enable = 1'b0;
                checks++;
                if (rd !== 5'(1 + k + 4*f) || rd_value_write_enable !== 1'b1 ||
                    rd_value_write_data !== 32'hA000_0000 + 32'(f * 16 + k)) begin
                    failures++;
                    $display("FAIL drain fill%0d pop%0d: rd=%0d we=%b data=%h, want rd=%0d we=1 data=%h",
                             f, k, rd, rd_value_write_enable, rd_value_write_data,
                             1 + k + 4*f, 32'hA000_0000 + 32'(f * 16 + k));
                end
            end
            system_bus_read_data_valid = 1'b0;
            step();
            checks++;
            if (rd_value_write_enable !== 1'b0 || loads_pending !== 1'b0 || issue_ready !== 1'b1) begin
                failures++;
                $display("FAIL drained fill%0d: we=%b pend=%b ready=%b, want 0 0 1",
                         f, rd_value_write_enable, loads_pending, issue_ready);
            end
        end
    endtask

    task automatic test_hazard();
        issue_enable = 1'b1; issue_rd = 5'd7; issue_funct3 = 3'b010; issue_addr_lsbs = 2'd0;
        step();
        issue_enable = 1'b0;
        query_rs1 = 5'd7; query_rs2 = 5'd3; #1;
        checks++;
        if (load_hazard !== 1'b1) begin
            failures++; $display("FAIL hazard_rs1: hazard=%b, want 1", load_hazard);
        end
        query_rs1 = 5'd0; query_rs2 = 5'd7; #1;
        checks++;
        if (load_hazard !== 1'b1) begin
            failures++; $display("FAIL hazard_rs2: hazard=%b, want 1", load_hazard);
        end
        query_rs1 = 5'd8; query_rs2 = 5'd0; #1;
        checks++;
        if (load_hazard !== 1'b0) begin
            failures++; $display("FAIL hazard_miss: hazard=%b, want 0", load_hazard);
        end
        query_rs1 = 5'd7;
        system_bus_read_data_valid = 1'b1; system_bus_read_data = 32'h1;
        step();
        system_bus_read_data_valid = 1'b0;
        checks++;
        if (load_hazard !== 1'b1 || rd_value_write_enable !== 1'b1 || loads_pending !== 1'b1) begin
            failures++;
            $display("FAIL hazard_wb_cycle: hazard=%b we=%b pend=%b, want 1 1 1",
                     load_hazard, rd_value_write_enable, loads_pending);
        end
        step();
        checks++;
        if (load_hazard !== 1'b0) begin
            failures++; $display("FAIL hazard_after_wb: hazard=%b, want 0", load_hazard);
        end
        // x0 destination: it is pending but never hazards and never writes.
        issue_enable = 1'b1; issue_rd = 5'd0;
        step();
        issue_enable = 1'b0;
        query_rs1 = 5'd0; query_rs2 = 5'd0; #1;
        checks++;
        if (load_hazard !== 1'b0 || loads_pending !== 1'b1) begin
            failures++;
            $display("FAIL hazard_x0: hazard=%b pend=%b, want 0 1", load_hazard, loads_pending);
        end
        system_bus_read_data_valid = 1'b1; system_bus_read_data = 32'hFFFF_FFFF;
        step();
        system_bus_read_data_valid = 1'b0;
        checks++;
        if (rd_value_write_enable !== 1'b0 || loads_pending !== 1'b0) begin
            failures++;
            $display("FAIL x0_pop: we=%b pend=%b, want 0 0", rd_value_write_enable, loads_pending);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        issue_enable = 1'b1; issue_rd = 5'd12; issue_funct3 = 3'b010; issue_addr_lsbs = 2'd2;
        step();
        issue_enable = 1'b0;
        checks++;
        if (load_error !== ERR_EXP) begin
            failures++; $display("FAIL misalign_err: load_error=%b, want %b", load_error, ERR_EXP);
        end
        system_bus_read_data_valid = 1'b1; system_bus_read_data = 32'hDEAD_BEEF;
        step();
        system_bus_read_data_valid = 1'b0;
        checks++;
        if (rd !== 5'd12 || rd_value_write_enable !== 1'b1 || rd_value_write_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL misalign_data: rd=%0d we=%b data=%h, want 12 1 deadbeef",
                     rd, rd_value_write_enable, rd_value_write_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            issue_enable = 1'b1; issue_rd = 5'(20 + k); issue_funct3 = 3'b010; issue_addr_lsbs = 2'd0;
            step();
        end
        issue_enable = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (loads_pending !== 1'b0 || issue_ready !== 1'b1 || load_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: pend=%b ready=%b err=%b, want 0 1 0", loads_pending, issue_ready, load_error);
        end
        system_bus_read_data_valid = 1'b1; system_bus_read_data = 32'h5555_AAAA;
        step();
        system_bus_read_data_valid = 1'b0;
        checks++;
        if (rd_value_write_enable !== 1'b0 || load_error !== ERR_EXP) begin
            failures++;
            $display("FAIL orphan_return: we=%b err=%b, want 0 %b", rd_value_write_enable, load_error, ERR_EXP);
        end
        step();
        checks++;
        if (load_error !== ERR_EXP || rd_value_write_enable !== 1'b0) begin
            failures++;
            $display("FAIL error_sticky: err=%b we=%b, want %b 0", load_error, rd_value_write_enable, ERR_EXP);
        end
    endtask

    initial begin
        reset = 1'b1; issue_enable = 1'b0; issue_rd = '0; issue_funct3 = '0; issue_addr_lsbs = '0;
        system_bus_read_data = '0; system_bus_read_data_valid = 1'b0;
        query_rs1 = '0; query_rs2 = '0;
        #2;
        test_reset();
        test_align();
        test_back_to_back();
        test_hazard();
        test_misaligned();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
